aes256_ctr_decrypt_stream: RTL and testbench

Streaming AES-256-CTR decryptor. It takes ciphertext one 128-bit block at a time over a valid/ready handshake and returns plaintext blocks over a second valid/ready handshake. Keystream generation is delegated to the existing AES-256 encryption core, instantiated by the parent. This block drives the core's counter block and consumes its keystream and done pulse. It is the receive-side counterpart of the CTR encryption wrapper and is sized for arbitrary-length messages instead of a fixed-width vector.

---
 rtl/aes256_ctr_decrypt_stream.sv | 144 ++++++++++++++
 tb/tb_aes256_ctr_decrypt_stream.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes256_ctr_decrypt_stream.sv
// Streaming AES-256-CTR decryptor.
// It accepts ciphertext blocks one at a time. For each block it asks the external AES core to
// encrypt the current counter block, XORs the keystream with the ciphertext and presents the
// plaintext downstream. Only one block is in flight at a time. The counter advances with a full
// 128-bit carry.
module aes256_ctr_decrypt_stream #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [127:0]     iv_i,
  input  logic [CNT_W-1:0] num_blocks_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [127:0]     ks_counter_o,
  output logic             ks_req_o,
  input  logic             ks_done_i,
  input  logic [127:0]     ks_keystream_i,
  input  logic             ct_valid_i,
  output logic             ct_ready_o,
  input  logic [127:0]     ct_data_i,
  output logic             pt_valid_o,
  input  logic             pt_ready_i,
  output logic [127:0]     pt_data_o,
  output logic [CNT_W-1:0] blocks_left_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_GEN,
    S_CT,
    S_OUT,
    S_FIN
  } state_t;

  state_t           state, state_nxt;
  logic             busy_nxt, done_nxt, ks_req_nxt, ct_ready_nxt, pt_valid_nxt;
  logic [127:0]     ks_counter_nxt, pt_data_nxt;
  logic [CNT_W-1:0] blocks_left_nxt;
  logic [127:0]     keystream_q;
  logic             ks_cap;

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_nxt       = state;
    busy_nxt        = busy_o;
    done_nxt        = 1'b0;
    ks_req_nxt      = 1'b0;
    ct_ready_nxt    = 1'b0;
    pt_valid_nxt    = pt_valid_o;
    ks_counter_nxt  = ks_counter_o;
    pt_data_nxt     = pt_data_o;
    blocks_left_nxt = blocks_left_o;
    ks_cap          = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          if (num_blocks_i != '0) begin
            ks_counter_nxt  = iv_i;
            blocks_left_nxt = num_blocks_i;
            busy_nxt        = 1'b1;
            ks_req_nxt      = 1'b1;
            state_nxt       = S_REQ;
          end else begin
            // Empty message: report completion without touching the core.
            done_nxt = 1'b1;
          end
        end
      end
      S_REQ: begin
        // ks_req_o is high only while in REQ, so it is a single-cycle pulse.
        state_nxt = S_GEN;
      end
      S_GEN: begin
        if (ks_done_i) begin
          ks_cap       = 1'b1;
          ct_ready_nxt = 1'b1;
          state_nxt    = S_CT;
        end
      end
      S_CT: begin
        ct_ready_nxt = 1'b1;
        if (ct_valid_i && ct_ready_o) begin
          pt_data_nxt     = ct_data_i ^ keystream_q;
          pt_valid_nxt    = 1'b1;
          ct_ready_nxt    = 1'b0;
          ks_counter_nxt  = ks_counter_o + 128'd1;
          blocks_left_nxt = blocks_left_o - CNT_W'(1);
          state_nxt       = S_OUT;
        end
      end
      S_OUT: begin
        if (pt_valid_o && pt_ready_i) begin
          pt_valid_nxt = 1'b0;
          if (blocks_left_o == '0) begin
            state_nxt = S_FIN;
          end else begin
            ks_req_nxt = 1'b1;
            state_nxt  = S_REQ;
          end
        end
      end
      S_FIN: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and output registers. An asynchronous reset clears everything that is visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      ks_req_o      <= 1'b0;
      ct_ready_o    <= 1'b0;
      pt_valid_o    <= 1'b0;
      ks_counter_o  <= '0;
      pt_data_o     <= '0;
      blocks_left_o <= '0;
    end else begin
      state         <= state_nxt;
      busy_o        <= busy_nxt;
      done_o        <= done_nxt;
      ks_req_o      <= ks_req_nxt;
      ct_ready_o    <= ct_ready_nxt;
      pt_valid_o    <= pt_valid_nxt;
      ks_counter_o  <= ks_counter_nxt;
      pt_data_o     <= pt_data_nxt;
      blocks_left_o <= blocks_left_nxt;
    end
  end

  // Keystream holding register. It is loaded only in GEN, so stray core pulses are ignored.
  always_ff @(posedge clk) begin
    if (ks_cap) keystream_q <= ks_keystream_i;
  end

endmodule

// File: tb/tb_aes256_ctr_decrypt_stream.sv
// Testbench for aes256_ctr_decrypt_stream: a model AES core, random handshakes and a reference model.
module tb_aes256_ctr_decrypt_stream;
  localparam int CNT_W = 16;

  logic             clk, rst_n, start_i;
  logic [127:0]     iv_i;
  logic [CNT_W-1:0] num_blocks_i;
  logic             busy_o, done_o, ks_req_o, ks_done_i;
  logic [127:0]     ks_counter_o, ks_keystream_i;
  logic             ct_valid_i, ct_ready_o, pt_valid_o, pt_ready_i;
  logic [127:0]     ct_data_i, pt_data_o;
  logic [CNT_W-1:0] blocks_left_o;

  aes256_ctr_decrypt_stream #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .iv_i(iv_i), .num_blocks_i(num_blocks_i),
    .busy_o(busy_o), .done_o(done_o), .ks_counter_o(ks_counter_o), .ks_req_o(ks_req_o),
    .ks_done_i(ks_done_i), .ks_keystream_i(ks_keystream_i), .ct_valid_i(ct_valid_i),
    .ct_ready_o(ct_ready_o), .ct_data_i(ct_data_i), .pt_valid_o(pt_valid_o),
    .pt_ready_i(pt_ready_i), .pt_data_o(pt_data_o), .blocks_left_o(blocks_left_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] ctr;
    logic [127:0] ks;
    logic [127:0] ct;
    logic [127:0] pt;
  } nist_t;
  nist_t nist[4];

  typedef struct {
    logic [127:0] iv;
    int n;
    int ct_gap;
    int pmode;
    int lat;
    int special;
  } scen_t;
  scen_t scen[6];

  int chk_cnt = 0, pass_cnt = 0;
  int pt_mode = 0, core_lat = 1;
  int stray_req = 0, stray_done = 0;
  int hs_cnt = 0, done_cnt = 0, hs_at_done = 0, req_hi_cnt = 0, stab_bad = 0;
  logic [127:0] ct_q[$], exp_pt_q[$], exp_ctr_q[$], got_pt_q[$], got_ctr_q[$];

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Model AES core: NIST outputs for the NIST counters, otherwise a fixed mix of the counter.
  function automatic logic [127:0] ks_fn(input logic [127:0] c);
    for (int k = 0; k < 4; k++) if (c == nist[k].ctr) return nist[k].ks;
    return {c[63:0], c[127:64]} ^ 128'h5a5a_c3c3_0f0f_9696_1234_5678_9abc_def0 ^
           {4{c[31:0] * 32'h9e37_79b9}};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Downstream ready: 0 = always ready, 1 = random, 2 = never ready.
  initial begin
    pt_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      pt_ready_i = (pt_mode == 0) ? 1'b1 : (pt_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Model AES core, with an optional stray done pulse.
  initial begin
    logic [127:0] c;
    ks_done_i = 1'b0;
    ks_keystream_i = '0;
    forever begin
      @(negedge clk);
      if (rst_n && ks_req_o) begin
        c = ks_counter_o;
        got_ctr_q.push_back(c);
        repeat (core_lat) @(posedge clk);
        #1;
        ks_done_i = 1'b1;
        ks_keystream_i = ks_fn(c);
        @(posedge clk);
        #1;
        ks_done_i = 1'b0;
        ks_keystream_i = rand128();
      end else if (stray_req != stray_done) begin
        stray_done++;
        ks_done_i = 1'b1;
        ks_keystream_i = rand128();
        @(negedge clk);
        ks_done_i = 1'b0;
      end
    end
  end

  // Output monitor: handshakes, done pulses, request cycles and hold stability.
  initial begin
    logic prev_hold;
    logic [127:0] prev_data;
    prev_hold = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold && (!pt_valid_o || pt_data_o !== prev_data)) stab_bad++;
        if (pt_valid_o && pt_ready_i) begin
          got_pt_q.push_back(pt_data_o);
          hs_cnt++;
        end
        if (ks_req_o) req_hi_cnt++;
        if (done_o) begin
          done_cnt++;
          hs_at_done = hs_cnt;
        end
        prev_hold = pt_valid_o && !pt_ready_i;
        prev_data = pt_data_o;
      end
    end
  end

  task automatic feed_ct(input logic [127:0] blk, input int gap, output bit ok);
    ok = 1'b0;
    repeat ($urandom_range(0, gap)) tick();
    ct_valid_i = 1'b1;
    ct_data_i = blk;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (ct_ready_o) begin
        @(posedge clk);
        #1;
        ct_valid_i = 1'b0;
        ct_data_i = rand128();
        ok = 1'b1;
        break;
      end
    end
    ct_valid_i = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"}, 128'(busy_o), 128'(0));
    chk({tag, "_done"}, 128'(done_o), 128'(0));
    chk({tag, "_ks_req"}, 128'(ks_req_o), 128'(0));
    chk({tag, "_ct_ready"}, 128'(ct_ready_o), 128'(0));
    chk({tag, "_pt_valid"}, 128'(pt_valid_o), 128'(0));
    chk({tag, "_ks_counter"}, ks_counter_o, 128'(0));
    chk({tag, "_pt_data"}, pt_data_o, 128'(0));
    chk({tag, "_blocks_left"}, 128'(blocks_left_o), 128'(0));
  endtask

  // special: 0 none, 1 start pulse while busy, 2 stray core done while holding in OUT
  task automatic run_msg(input logic [127:0] iv, input int n, input int ct_gap,
                         input int pmode, input int special);
    int pt_base, ctr_base, hs_base, done_base, req_base, stab_base;
    bit ok;
    logic [127:0] d;
    exp_pt_q.delete();
    exp_ctr_q.delete();
    for (int k = 0; k < n; k++) begin
      exp_ctr_q.push_back(iv + 128'(k));
      exp_pt_q.push_back(ct_q[k] ^ ks_fn(iv + 128'(k)));
    end
    pt_base = got_pt_q.size();
    ctr_base = got_ctr_q.size();
    hs_base = hs_cnt;
    done_base = done_cnt;
    req_base = req_hi_cnt;
    stab_base = stab_bad;
    pt_mode = pmode;
    start_i = 1'b1;
    iv_i = iv;
    num_blocks_i = CNT_W'(n);
    tick();
    start_i = 1'b0;
    iv_i = rand128();
    num_blocks_i = CNT_W'($urandom);
    chk("busy_after_start", 128'(busy_o), 128'(1));
    chk("blocks_left_init", 128'(blocks_left_o), 128'(n));
    chk("ctr_init", ks_counter_o, iv);
    for (int k = 0; k < n; k++) begin
      feed_ct(ct_q[k], ct_gap, ok);
      if (!ok) begin
        chk("ct_accept_timeout", 128'(0), 128'(1));
        break;
      end
      if (k == 0 && special == 1) begin
        start_i = 1'b1;
        iv_i = rand128();
        num_blocks_i = CNT_W'(7);
        tick();
        start_i = 1'b0;
      end
      if (k == 0 && special == 2) begin
        for (int i = 0; i < 100 && !pt_valid_o; i++) tick();
        d = pt_data_o;
        stray_req++;
        repeat (4) tick();
        chk("stray_pt_valid", 128'(pt_valid_o), 128'(1));
        chk("stray_pt_data", pt_data_o, d);
        chk("stray_ct_ready", 128'(ct_ready_o), 128'(0));
        chk("stray_blocks_left", 128'(blocks_left_o), 128'(n - 1));
        pt_mode = 0;
      end
    end
    for (int i = 0; i < 4000 && done_cnt == done_base; i++) tick();
    repeat (3) tick();
    chk("done_count", 128'(done_cnt - done_base), 128'(1));
    chk("done_after_last_pt", 128'(hs_at_done - hs_base), 128'(n));
    chk("ks_req_count", 128'(req_hi_cnt - req_base), 128'(n));
    chk("pt_count", 128'(got_pt_q.size() - pt_base), 128'(n));
    chk("ctr_count", 128'(got_ctr_q.size() - ctr_base), 128'(n));
    chk("pt_hold_stable", 128'(stab_bad - stab_base), 128'(0));
    for (int k = 0; k < n; k++) begin
      if (pt_base + k < got_pt_q.size()) chk("pt_block", got_pt_q[pt_base + k], exp_pt_q[k]);
      if (ctr_base + k < got_ctr_q.size()) chk("ks_counter", got_ctr_q[ctr_base + k], exp_ctr_q[k]);
    end
    chk("busy_end", 128'(busy_o), 128'(0));
    chk("blocks_left_end", 128'(blocks_left_o), 128'(0));
  endtask

  initial begin
    int b, dbase, rbase;
    bit ok;
    nist[0] = '{128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, 128'h0bdf7df1591716335e9a8b15c860c502,
                128'h601ec313775789a5b7a7f504bbf3d228, 128'h6bc1bee22e409f96e93d7e117393172a};
    nist[1] = '{128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00, 128'h5a6e699d536119065433863c8f657b94,
                128'hf443e3ca4d62b59aca84e990cacaf5c5, 128'hae2d8a571e03ac9c9eb76fac45af8e51};
    nist[2] = '{128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff01, 128'h1bc12c9c01610d5d0d8bd6a3378eca62,
                128'h2b0930daa23de94ce87017ba2d84988d, 128'h30c81c46a35ce411e5fbc1191a0a52ef};
    nist[3] = '{128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff02, 128'h2956e1c8693536b1bee99c73a31576b6,
                128'hdfc9c58db67aada613c2dd08457941a6, 128'hf69f2445df4f9b17ad2b417be66c3710};
    scen[0] = '{rand128(), 3, 0, 0, 1, 0};
    scen[1] = '{rand128(), 5, 3, 1, 3, 0};
    scen[2] = '{rand128(), 4, 2, 1, 2, 1};
    scen[3] = '{rand128(), 2, 0, 2, 1, 2};
    scen[4] = '{rand128(), 8, 4, 1, 4, 0};
    scen[5] = '{{64'hffff_ffff_ffff_ffff, 64'hffff_ffff_ffff_fffe}, 4, 1, 1, 2, 0};

    rst_n = 1'b0;
    start_i = 1'b0;
    iv_i = '0;
    num_blocks_i = '0;
    ct_valid_i = 1'b0;
    ct_data_i = '0;
    #1;
    check_idle_zero("reset");
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Single NIST block
    core_lat = 5;
    ct_q.delete();
    ct_q.push_back(nist[0].ct);
    b = got_pt_q.size();
    run_msg(nist[0].ctr, 1, 0, 0, 0);
    if (b < got_pt_q.size()) chk("nist1_pt", got_pt_q[b], nist[0].pt);

    // Four NIST blocks, checked against the table
    core_lat = 3;
    ct_q.delete();
    for (int k = 0; k < 4; k++) ct_q.push_back(nist[k].ct);
    b = got_pt_q.size();
    dbase = got_ctr_q.size();
    run_msg(nist[0].ctr, 4, 1, 1, 0);
    for (int k = 0; k < 4; k++) begin
      if (b + k < got_pt_q.size()) chk("nist4_pt", got_pt_q[b + k], nist[k].pt);
      if (dbase + k < got_ctr_q.size()) chk("nist4_ctr", got_ctr_q[dbase + k], nist[k].ctr);
    end

    // Counter wrap from all-ones
    core_lat = 2;
    ct_q.delete();
    repeat (2) ct_q.push_back(rand128());
    dbase = got_ctr_q.size();
    run_msg({128{1'b1}}, 2, 0, 0, 0);
    if (dbase + 1 < got_ctr_q.size()) chk("wrap_ctr_zero", got_ctr_q[dbase + 1], 128'(0));

    // Randomized scenarios
    for (int s = 0; s < 6; s++) begin
      core_lat = scen[s].lat;
      ct_q.delete();
      for (int k = 0; k < scen[s].n; k++) ct_q.push_back(rand128());
      run_msg(scen[s].iv, scen[s].n, scen[s].ct_gap, scen[s].pmode, scen[s].special);
    end

    // Empty message
    dbase = done_cnt;
    rbase = req_hi_cnt;
    start_i = 1'b1;
    num_blocks_i = '0;
    iv_i = rand128();
    tick();
    start_i = 1'b0;
    chk("zero_done_pulse", 128'(done_o), 128'(1));
    chk("zero_busy", 128'(busy_o), 128'(0));
    tick();
    chk("zero_done_drop", 128'(done_o), 128'(0));
    repeat (5) tick();
    chk("zero_no_req", 128'(req_hi_cnt - rbase), 128'(0));
    chk("zero_done_count", 128'(done_cnt - dbase), 128'(1));

    // Asynchronous reset while holding a plaintext block
    core_lat = 1;
    pt_mode = 2;
    start_i = 1'b1;
    iv_i = rand128();
    num_blocks_i = CNT_W'(2);
    tick();
    start_i = 1'b0;
    feed_ct(rand128(), 0, ok);
    chk("rst_first_ct_accepted", 128'(ok), 128'(1));
    for (int i = 0; i < 100 && !pt_valid_o; i++) tick();
    chk("rst_pt_valid_before", 128'(pt_valid_o), 128'(1));
    dbase = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_zero("async_rst");
    repeat (2) tick();
    rst_n = 1'b1;
    pt_mode = 0;
    repeat (3) tick();
    chk("rst_no_done", 128'(done_cnt - dbase), 128'(0));
    ct_q.delete();
    repeat (3) ct_q.push_back(rand128());
    run_msg(rand128(), 3, 1, 1, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
